// File: rtl/fifo_reader.sv
// fifo_reader: read engine for a 4-deep FIFO presenting bytes on a valid/ready stream; define FIFO_READER_CNT_EN for the rd_count counter
module fifo_reader #(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [15:0]       rd_count
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t            state;
  logic [1:0]        occ;
  logic              inflight;
  logic              pop;
  logic [DATA_W-1:0] hd;
  logic [DATA_W-1:0] tl;
  assign out_valid  = occ != 2'd0;
  assign pop        = out_valid && out_ready;
  assign out_data   = hd;
  assign busy       = state != IDLE;
  assign fifo_rd_en = state == RUN && en && !fifo_empty &&
                      ({1'b0, occ} + {2'b0, inflight} - {2'b0, pop}) < 3'(BUF_DEPTH);
  // control state: run while enabled, then drain outstanding bytes before idling
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else
      case (state)
        IDLE:    state <= en ? RUN : IDLE;
        RUN:     state <= en ? RUN : DRAIN;
        DRAIN:   state <= (occ == 2'd0 && !inflight) ? (en ? RUN : IDLE) : DRAIN;
        default: state <= IDLE;
      endcase
  // two-entry buffer: capture the byte returned one cycle after a read, shift on pop
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      inflight <= 1'b0;
      occ      <= 2'd0;
      hd       <= '0;
      tl       <= '0;
    end else begin
      inflight <= fifo_rd_en;
      occ      <= 2'(occ + {1'b0, inflight} - {1'b0, pop});
      hd       <= (pop && occ == 2'd2) ? tl :
                  (inflight && (occ == 2'd0 || (pop && occ == 2'd1))) ? fifo_data : hd;
      tl       <= (inflight && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop))) ? fifo_data : tl;
    end
`ifdef FIFO_READER_CNT_EN
  // count delivered bytes, wrapping at 16 bits
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) rd_count <= 16'd0;
    else if (pop) rd_count <= rd_count + 16'd1;
`else
  assign rd_count = 16'd0;
`endif
endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
Read-side engine for the 8-bit, 4-deep synchronous FIFO. It issues rd_en only when the FIFO reports non-empty, accounts for the FIFO's one-cycle registered data_out latency, and re-presents the bytes on a valid/ready stream towards downstream consumers. A 2-entry output buffer allows one byte per cycle of sustained throughput with full backpressure support.

Parameters:
DATA_W, 8, stream/FIFO data width
BUF_DEPTH, 2, output buffer entries (fixed at 2; other values unsupported)

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
en  input  1  level enable; 1 = fetch from FIFO, 0 = stop fetching and drain
fifo_empty  input  1  upstream FIFO empty flag (combinational in FIFO)
fifo_data  input  DATA_W  upstream FIFO data_out (valid cycle after accepted rd_en)
fifo_rd_en  output  1  read strobe to upstream FIFO
out_valid  output  1  stream byte available
out_ready  input  1  downstream accepts byte
out_data  output  DATA_W  stream byte
busy  output  1  state != IDLE
rd_count  output  16  accepted output bytes (see Optional Feature)

Behaviour:
- Clock/reset: single clock clk; rstn asynchronous active-low. Reset: state=IDLE, occ=0, inflight=0, buffer contents=0, out_valid=0, out_data=0, fifo_rd_en=0, busy=0, rd_count=0.
- Upstream contract: the FIFO honours every rd_en asserted while fifo_empty=0; the byte appears on fifo_data in the following cycle.
- inflight: register, set to 1 in the cycle after fifo_rd_en=1, else 0. In that cycle fifo_data is written into the buffer tail (occ+1).
- pop = out_valid && out_ready; it removes the buffer head (occ-1). Capture and pop in the same cycle are legal: occ is unchanged and order is preserved.
- fifo_rd_en = (state==RUN) && en && !fifo_empty && (occ + inflight - pop) < 2. It is combinational and may depend on out_ready in the same cycle.
- out_valid = (occ != 0). out_data = buffer head. out_data is registered and only changes on pop or on capture into an empty buffer.
- Latency: fifo_rd_en in cycle N, data captured at the end of N+1, out_valid=1 in N+2. With out_ready=1 held, bytes come out back-to-back, one per cycle.
- Backpressure: with out_ready=0, at most 2 bytes are buffered and fifo_rd_en stays 0 until space frees. No byte is ever dropped or duplicated.
- State machine:
  - IDLE: en=1 -> RUN.
  - RUN: en=0 -> DRAIN. fifo_rd_en is only asserted in RUN.
  - DRAIN: no new reads; in-flight byte still captured; buffered bytes still delivered. When occ=0 and inflight=0: en=1 -> RUN, otherwise -> IDLE.
- FIFO empty mid-burst: fifo_rd_en drops the same cycle; buffered bytes continue draining; reads resume automatically when not empty.
- Reset mid-operation: in-flight and buffered bytes are discarded and all outputs return to reset values. The upstream FIFO is reset by the same rstn.
- Order: strictly FIFO order from upstream to stream.

Optional Feature:
FIFO_READER_CNT_EN:
- Defined: rd_count increments by 1 on each pop and wraps 0xFFFF -> 0x0000. Cleared only by reset.
- Undefined: rd_count is tied to 0, no counter logic is present, and the port remains.

Test Plan:
- Reset with rstn=0 -> out_valid=0, fifo_rd_en=0, busy=0, rd_count=0. Release with en=0 and FIFO holding data -> no fifo_rd_en.
- FIFO holds 0xA5, en=1, out_ready=1 -> one fifo_rd_en pulse; out_valid=1 with 0xA5 two cycles later; back to no reads once FIFO empty.
- FIFO holds 0x11,0x22,0x33; out_ready=1 -> three consecutive fifo_rd_en cycles; out_data 0x11,0x22,0x33 on consecutive cycles.
- Same 3 bytes with out_ready=0 -> exactly 2 reads issued, 0x11 held on out_data. Raise out_ready -> 0x11,0x22,0x33 delivered in order, third read issued.
- en dropped 1 cycle after the first rd_en, with 4 bytes in FIFO -> DRAIN delivers exactly the fetched bytes, then IDLE, busy=0, and 3 bytes remain in FIFO.
- With FIFO_READER_CNT_EN, preload rd_count path via 65537 pops -> rd_count=1. Assert rstn=0 during a burst -> outputs zero immediately (asynchronously).
